// File: rtl/pe_act_read_arbiter.sv
// Read-port arbiter for the PE activation register file: COMP has priority,
// BROADCAST is protected by a starvation counter, and read data is routed back to its issuer.
module pe_act_read_arbiter #(
  parameter int ACT_NO_WIDTH   = 4,
  parameter int ACT_DATA_WIDTH = 16,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      comp_req,
  input  logic [ACT_NO_WIDTH-1:0]   comp_addr,
  output logic                      comp_gnt,
  input  logic                      broadcast_req,
  input  logic [ACT_NO_WIDTH-1:0]   broadcast_addr,
  output logic                      broadcast_gnt,
  output logic                      in_act_read_en,
  output logic [ACT_NO_WIDTH-1:0]   in_act_read_addr,
  input  logic [ACT_DATA_WIDTH-1:0] in_act_read_data,
  output logic                      comp_rdata_valid,
  output logic [ACT_DATA_WIDTH-1:0] comp_rdata,
  output logic                      broadcast_rdata_valid,
  output logic [ACT_DATA_WIDTH-1:0] broadcast_rdata,
  output logic                      busy
);

  typedef enum logic {
    OWNER_COMP = 1'b0,
    OWNER_BC   = 1'b1
  } owner_e;

  // Four bits cover the whole legal STARVE_LIMIT range of 1..15.
  localparam int                CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]          starve_cnt_q, starve_cnt_d;
  logic                      force_bc;
  logic                      tag_valid_q;
  owner_e                    tag_owner_q;
  logic                      comp_rdata_valid_q, broadcast_rdata_valid_q;
  logic [ACT_DATA_WIDTH-1:0] comp_rdata_q, broadcast_rdata_q;

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    force_bc      = broadcast_req && (starve_cnt_q == LIMIT);
    comp_gnt      = 1'b0;
    broadcast_gnt = 1'b0;
    // Grants are held low while reset is asserted.
    if (rst_n) begin
      if (force_bc)           broadcast_gnt = 1'b1;
      else if (comp_req)      comp_gnt      = 1'b1;
      else if (broadcast_req) broadcast_gnt = 1'b1;
    end

    in_act_read_en   = comp_gnt | broadcast_gnt;
    in_act_read_addr = '0;
    if (comp_gnt)           in_act_read_addr = comp_addr;
    else if (broadcast_gnt) in_act_read_addr = broadcast_addr;

    starve_cnt_d = starve_cnt_q;
    if (!broadcast_req || broadcast_gnt) starve_cnt_d = '0;
    else if (starve_cnt_q < LIMIT)       starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q            <= '0;
      tag_valid_q             <= 1'b0;
      tag_owner_q             <= OWNER_COMP;
      comp_rdata_valid_q      <= 1'b0;
      broadcast_rdata_valid_q <= 1'b0;
      comp_rdata_q            <= '0;
      broadcast_rdata_q       <= '0;
    end else begin
      starve_cnt_q            <= starve_cnt_d;
      tag_valid_q             <= in_act_read_en;
      tag_owner_q             <= broadcast_gnt ? OWNER_BC : OWNER_COMP;
      comp_rdata_valid_q      <= tag_valid_q && (tag_owner_q == OWNER_COMP);
      broadcast_rdata_valid_q <= tag_valid_q && (tag_owner_q == OWNER_BC);
      // Register file data is valid the cycle after the grant, while the tag sits in stage 1.
      if (tag_valid_q && (tag_owner_q == OWNER_COMP)) comp_rdata_q      <= in_act_read_data;
      if (tag_valid_q && (tag_owner_q == OWNER_BC))   broadcast_rdata_q <= in_act_read_data;
    end
  end

  assign comp_rdata_valid      = comp_rdata_valid_q;
  assign comp_rdata            = comp_rdata_q;
  assign broadcast_rdata_valid = broadcast_rdata_valid_q;
  assign broadcast_rdata       = broadcast_rdata_q;
  assign busy                  = tag_valid_q | comp_rdata_valid_q | broadcast_rdata_valid_q;

endmodule

// File: tb/tb_pe_act_read_arbiter.sv
// Directed bench for pe_act_read_arbiter: a cycle-by-cycle vector table plus
// hand sequences for reset, starvation-counter clearing and reset mid-flight.
module tb_pe_act_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic        comp_req, broadcast_req;
  logic [3:0]  comp_addr, broadcast_addr;
  logic        comp_gnt, broadcast_gnt;
  logic        in_act_read_en;
  logic [3:0]  in_act_read_addr;
  logic [15:0] in_act_read_data;
  logic        comp_rdata_valid, broadcast_rdata_valid;
  logic [15:0] comp_rdata, broadcast_rdata;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  pe_act_read_arbiter #(
    .ACT_NO_WIDTH(4), .ACT_DATA_WIDTH(16), .STARVE_LIMIT(4)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .comp_req             (comp_req),
    .comp_addr            (comp_addr),
    .comp_gnt             (comp_gnt),
    .broadcast_req        (broadcast_req),
    .broadcast_addr       (broadcast_addr),
    .broadcast_gnt        (broadcast_gnt),
    .in_act_read_en       (in_act_read_en),
    .in_act_read_addr     (in_act_read_addr),
    .in_act_read_data     (in_act_read_data),
    .comp_rdata_valid     (comp_rdata_valid),
    .comp_rdata           (comp_rdata),
    .broadcast_rdata_valid(broadcast_rdata_valid),
    .broadcast_rdata      (broadcast_rdata),
    .busy                 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        creq;
    logic [3:0]  caddr;
    logic        breq;
    logic [3:0]  baddr;
    logic [15:0] rfd;
    logic        cg, bg, en;
    logic [3:0]  addr;
    logic        cv;
    logic [15:0] crd;
    logic        bv;
    logic [15:0] brd;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic creq, input logic [3:0] caddr,
                              input logic breq, input logic [3:0] baddr,
                              input logic [15:0] rfd,
                              input logic cg, input logic bg, input logic en,
                              input logic [3:0] addr,
                              input logic cv, input logic [15:0] crd,
                              input logic bv, input logic [15:0] brd,
                              input logic bsy);
    vec_t v;
    v.creq = creq; v.caddr = caddr; v.breq = breq; v.baddr = baddr; v.rfd = rfd;
    v.cg = cg; v.bg = bg; v.en = en; v.addr = addr;
    v.cv = cv; v.crd = crd; v.bv = bv; v.brd = brd; v.busy = bsy;
    return v;
  endfunction

  task automatic drive(input logic creq, input logic [3:0] caddr,
                       input logic breq, input logic [3:0] baddr, input logic [15:0] rfd);
    comp_req         = creq;
    comp_addr        = caddr;
    broadcast_req    = breq;
    broadcast_addr   = baddr;
    in_act_read_data = rfd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 4'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    string gseq;
    string exp_gseq;
    rst_n = 1'b0;
    drive(1'b1, 4'h7, 1'b1, 4'h8, 16'hFFFF);

    // Reset with both requests high: every output must be zero.
    #12;
    check("reset_outputs",
          {comp_gnt, broadcast_gnt, in_act_read_en, in_act_read_addr, comp_rdata_valid,
           comp_rdata, broadcast_rdata_valid, broadcast_rdata, busy}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_comp_gnt", {broadcast_gnt, comp_gnt, in_act_read_addr}, {1'b0, 1'b1, 4'h7});

    do_reset();

    //              creq caddr breq baddr rfd       cg bg en addr cv crd      bv brd      busy
    // single COMP read
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 16'h0000, 0, 0, 0, 4'h0, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(1, 4'h3, 0, 4'h0, 16'h0000, 1, 0, 1, 4'h3, 0, 16'h0000, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 16'hA5A5, 0, 0, 0, 4'h0, 0, 16'h0000, 0, 16'h0000, 1));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 16'h0000, 0, 0, 0, 4'h0, 1, 16'hA5A5, 0, 16'h0000, 1));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 16'h0000, 0, 0, 0, 4'h0, 0, 16'hA5A5, 0, 16'h0000, 0));
    // back-to-back C / B / C
    vecs.push_back(mk(1, 4'h1, 0, 4'h0, 16'h0000, 1, 0, 1, 4'h1, 0, 16'hA5A5, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 4'h0, 1, 4'h2, 16'h0011, 0, 1, 1, 4'h2, 0, 16'hA5A5, 0, 16'h0000, 1));
    vecs.push_back(mk(1, 4'h3, 0, 4'h0, 16'h0022, 1, 0, 1, 4'h3, 1, 16'h0011, 0, 16'h0000, 1));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 16'h0033, 0, 0, 0, 4'h0, 0, 16'h0011, 1, 16'h0022, 1));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 16'h0000, 0, 0, 0, 4'h0, 1, 16'h0033, 0, 16'h0022, 1));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 16'h0000, 0, 0, 0, 4'h0, 0, 16'h0033, 0, 16'h0022, 0));
    // continuous contention: C,C,C,C,B,C,C,C,C,B
    vecs.push_back(mk(1, 4'h5, 1, 4'h9, 16'h1234, 1, 0, 1, 4'h5, 0, 16'h0033, 0, 16'h0022, 0));
    vecs.push_back(mk(1, 4'h5, 1, 4'h9, 16'h1234, 1, 0, 1, 4'h5, 0, 16'h0033, 0, 16'h0022, 1));
    vecs.push_back(mk(1, 4'h5, 1, 4'h9, 16'h1234, 1, 0, 1, 4'h5, 1, 16'h1234, 0, 16'h0022, 1));
    vecs.push_back(mk(1, 4'h5, 1, 4'h9, 16'h1234, 1, 0, 1, 4'h5, 1, 16'h1234, 0, 16'h0022, 1));
    vecs.push_back(mk(1, 4'h5, 1, 4'h9, 16'h1234, 0, 1, 1, 4'h9, 1, 16'h1234, 0, 16'h0022, 1));
    vecs.push_back(mk(1, 4'h5, 1, 4'h9, 16'h1234, 1, 0, 1, 4'h5, 1, 16'h1234, 0, 16'h0022, 1));
    vecs.push_back(mk(1, 4'h5, 1, 4'h9, 16'h1234, 1, 0, 1, 4'h5, 0, 16'h1234, 1, 16'h1234, 1));
    vecs.push_back(mk(1, 4'h5, 1, 4'h9, 16'h1234, 1, 0, 1, 4'h5, 1, 16'h1234, 0, 16'h1234, 1));
    vecs.push_back(mk(1, 4'h5, 1, 4'h9, 16'h1234, 1, 0, 1, 4'h5, 1, 16'h1234, 0, 16'h1234, 1));
    vecs.push_back(mk(1, 4'h5, 1, 4'h9, 16'h1234, 0, 1, 1, 4'h9, 1, 16'h1234, 0, 16'h1234, 1));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 16'h1234, 0, 0, 0, 4'h0, 1, 16'h1234, 0, 16'h1234, 1));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 16'h0000, 0, 0, 0, 4'h0, 0, 16'h1234, 1, 16'h1234, 1));
    vecs.push_back(mk(0, 4'h0, 0, 4'h0, 16'h0000, 0, 0, 0, 4'h0, 0, 16'h1234, 0, 16'h1234, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].creq, vecs[i].caddr, vecs[i].breq, vecs[i].baddr, vecs[i].rfd);
      #1;
      check($sformatf("row%0d_ctl", i),
            {comp_gnt, broadcast_gnt, in_act_read_en, in_act_read_addr},
            {vecs[i].cg, vecs[i].bg, vecs[i].en, vecs[i].addr});
      check($sformatf("row%0d_rsp", i),
            {comp_rdata_valid, comp_rdata, broadcast_rdata_valid, broadcast_rdata, busy},
            {vecs[i].cv, vecs[i].crd, vecs[i].bv, vecs[i].brd, vecs[i].busy});
    end

    // Counter clear: 3 denied cycles, 1 cycle with broadcast_req low, then 4 more denials before a forced win.
    do_reset();
    gseq     = "";
    exp_gseq = "CCCCCCCCB";
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      drive(1'b1, 4'hA, (c != 3), 4'hB, 16'h0);
      #1;
      gseq = {gseq, broadcast_gnt ? "B" : (comp_gnt ? "C" : "-")};
    end
    check("starve_clear_grant_seq", 64'(gseq == exp_gseq), 64'd1);
    if (gseq != exp_gseq) $display("  grant sequence got %s, expected %s", gseq, exp_gseq);

    // Reset mid-flight: grant at T, reset during T+1, no response afterwards.
    do_reset();
    @(negedge clk);
    drive(1'b1, 4'h6, 1'b0, 4'h0, 16'h0);
    #1;
    check("midflight_grant", {comp_gnt, in_act_read_addr}, {1'b1, 4'h6});
    @(negedge clk);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 16'hBEEF);
    #1;
    check("midflight_tag_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midflight_reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_act_read_data = 16'h0;
    #1;
    check("midflight_no_valid_T2", {comp_rdata_valid, broadcast_rdata_valid, busy, comp_rdata}, '0);
    @(negedge clk);
    #1;
    check("midflight_no_valid_T3", {comp_rdata_valid, broadcast_rdata_valid, busy, comp_rdata}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
